ysyx_22040210_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port DPI-backed data memory (pmem_read/pmem_write model). The memory returns read data and write-done one cycle after the strobe.
- Shares the memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Enforces one outstanding transaction at a time, round-robin fairness and a response timeout.
- Sits between the IFU/LSU and the memory model in the SoC.

---
 rtl/ysyx_22040210_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22040210_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040210_mem_arbiter.sv
// rtl/ysyx_22040210_mem_arbiter.sv - IFU/LSU round-robin arbiter for the single-port data memory
module ysyx_22040210_mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MASK_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_gnt_o,
    output logic              ifu_rvalid_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_err_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [MASK_W-1:0] lsu_wmask_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              mem_ce_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [MASK_W-1:0] mem_we_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdatavalid_i,
    input  logic              mem_wdatavalid_i
);

    typedef enum logic [1:0] {IDLE, WAIT_IFU, WAIT_LSU_RD, WAIT_LSU_WR} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              last_lsu_q, last_lsu_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d;
    logic              ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

    logic              ifu_gnt, lsu_gnt, ren, wen, done, pick_lsu;
    logic [MASK_W-1:0] we;
    logic [ADDR_W-1:0] raddr, waddr;
    logic [DATA_W-1:0] wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b0;
            cnt_q       <= '0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            ifu_err_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            cnt_q       <= cnt_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
            ifu_err_q   <= ifu_err_d;
            lsu_err_q   <= lsu_err_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    // On a tie the requester that did not own the previous grant wins.
    assign pick_lsu = lsu_req_i && (!ifu_req_i || !last_lsu_q);

    always_comb begin
        state_d     = state_q;
        last_lsu_d  = last_lsu_q;
        cnt_d       = cnt_q;
        ifu_rv_d    = 1'b0;
        lsu_rv_d    = 1'b0;
        ifu_err_d   = 1'b0;
        lsu_err_d   = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_gnt     = 1'b0;
        lsu_gnt     = 1'b0;
        ren         = 1'b0;
        wen         = 1'b0;
        we          = '0;
        raddr       = '0;
        waddr       = '0;
        wdata       = '0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // The cycle carrying a response pulse is not a grant slot.
                if (!ifu_rv_q && !lsu_rv_q && (ifu_req_i || lsu_req_i)) begin
                    last_lsu_d = pick_lsu;
                    if (pick_lsu) begin
                        lsu_gnt = 1'b1;
                        if (lsu_we_i) begin
                            wen     = 1'b1;
                            waddr   = lsu_addr_i;
                            wdata   = lsu_wdata_i;
                            we      = lsu_wmask_i;
                            state_d = WAIT_LSU_WR;
                        end else begin
                            ren     = 1'b1;
                            raddr   = lsu_addr_i;
                            state_d = WAIT_LSU_RD;
                        end
                    end else begin
                        ifu_gnt = 1'b1;
                        ren     = 1'b1;
                        raddr   = ifu_addr_i;
                        state_d = WAIT_IFU;
                    end
                end
            end
            default: begin
                done = (state_q == WAIT_LSU_WR) ? mem_wdatavalid_i : mem_rdatavalid_i;
                if (done || cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (state_q == WAIT_IFU) begin
                        ifu_rv_d    = 1'b1;
                        ifu_err_d   = !done;
                        ifu_rdata_d = done ? mem_rdata_i : '0;
                    end else begin
                        lsu_rv_d    = 1'b1;
                        lsu_err_d   = !done;
                        lsu_rdata_d = (done && state_q == WAIT_LSU_RD) ? mem_rdata_i : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Every output is forced low while reset is held.
    assign mem_ce_o     = !rst;
    assign ifu_gnt_o    = ifu_gnt && !rst;
    assign lsu_gnt_o    = lsu_gnt && !rst;
    assign mem_ren_o    = ren && !rst;
    assign mem_wen_o    = wen && !rst;
    assign mem_we_o     = rst ? '0 : we;
    assign mem_raddr_o  = rst ? '0 : raddr;
    assign mem_waddr_o  = rst ? '0 : waddr;
    assign mem_wdata_o  = rst ? '0 : wdata;
    assign ifu_rvalid_o = ifu_rv_q && !rst;
    assign lsu_rvalid_o = lsu_rv_q && !rst;
    assign ifu_err_o    = ifu_err_q && !rst;
    assign lsu_err_o    = lsu_err_q && !rst;
    assign ifu_rdata_o  = rst ? '0 : ifu_rdata_q;
    assign lsu_rdata_o  = rst ? '0 : lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_22040210_mem_arbiter.sv
// tb/tb_ysyx_22040210_mem_arbiter.sv - self-checking bench for ysyx_22040210_mem_arbiter
module tb_ysyx_22040210_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, lsu_we;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err;
    logic [63:0] ifu_rdata, lsu_rdata;
    logic        mem_ce, mem_ren, mem_wen;
    logic [7:0]  mem_we;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata;
    logic        mem_silent, stray_rv, stray_wv;
    logic        rv_q = 1'b0, wv_q = 1'b0;
    logic [63:0] rd_q = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22040210_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt),
        .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata), .ifu_err_o(ifu_err),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .mem_ce_o(mem_ce), .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_we_o(mem_we),
        .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(rd_q), .mem_rdatavalid_i(rv_q | stray_rv),
        .mem_wdatavalid_i(wv_q | stray_wv)
    );

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'hDEAD_BEEF_0000_0013;
        return {~a[31:0], a[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: answers a strobe one cycle later unless told to stay silent.
    always @(posedge clk) begin
        rv_q <= mem_ren && !mem_silent;
        wv_q <= mem_wen && !mem_silent;
        rd_q <= mem_val(mem_raddr);
    end

    // Transaction-level model: a grant books a response 2 (or 16 on timeout)
    // cycles later, and the port is free again the cycle after that response.
    int          cyc = 0, free_at = 0, resp_at = -1;
    bit          last_lsu = 0, resp_ifu, resp_err, win_lsu;
    logic [63:0] resp_data;

    always @(negedge clk) begin
        logic e_ig, e_lg, e_ren, e_wen, e_irv, e_lrv, e_ierr, e_lerr;
        logic [7:0]  e_we;
        logic [63:0] e_raddr, e_waddr, e_wdata, e_data;
        e_ig = 0; e_lg = 0; e_ren = 0; e_wen = 0; e_irv = 0; e_lrv = 0;
        e_ierr = 0; e_lerr = 0; e_we = 0; e_raddr = 0; e_waddr = 0; e_wdata = 0;
        e_data = 0;
        if (rst) begin
            resp_at  = -1;
            free_at  = cyc + 1;
            last_lsu = 0;
            check("rst_ce", mem_ce, 1'b0);
            check("rst_ird", ifu_rdata, 64'd0);
            check("rst_lrd", lsu_rdata, 64'd0);
        end else begin
            check("ce", mem_ce, 1'b1);
            if (resp_at == cyc) begin
                e_data = resp_data;
                if (resp_ifu) begin e_irv = 1; e_ierr = resp_err; end
                else          begin e_lrv = 1; e_lerr = resp_err; end
                resp_at = -1;
            end
            if (cyc >= free_at && (ifu_req || lsu_req)) begin
                win_lsu  = lsu_req && !(ifu_req && last_lsu);
                last_lsu = win_lsu;
                resp_ifu = !win_lsu;
                resp_err = mem_silent;
                if (win_lsu && lsu_we) begin
                    e_lg = 1; e_wen = 1; e_waddr = lsu_addr; e_wdata = lsu_wdata; e_we = lsu_wmask;
                    resp_data = 0;
                end else begin
                    e_ren = 1;
                    e_raddr = win_lsu ? lsu_addr : ifu_addr;
                    if (win_lsu) e_lg = 1; else e_ig = 1;
                    resp_data = mem_silent ? 64'd0 : mem_val(e_raddr);
                end
                resp_at = cyc + (mem_silent ? 16 : 2);
                free_at = resp_at + 1;
            end
            if (e_irv) begin
                check("ifu_rdata", ifu_rdata, e_data);
                check("ifu_err", ifu_err, e_ierr);
            end
            if (e_lrv) begin
                check("lsu_rdata", lsu_rdata, e_data);
                check("lsu_err", lsu_err, e_lerr);
            end
        end
        check("ifu_gnt", ifu_gnt, e_ig);
        check("lsu_gnt", lsu_gnt, e_lg);
        check("ifu_rvalid", ifu_rvalid, e_irv);
        check("lsu_rvalid", lsu_rvalid, e_lrv);
        check("mem_ren", mem_ren, e_ren);
        check("mem_wen", mem_wen, e_wen);
        check("mem_we", mem_we, e_we);
        check("mem_raddr", mem_raddr, e_raddr);
        check("mem_waddr", mem_waddr, e_waddr);
        check("mem_wdata", mem_wdata, e_wdata);
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int g_cyc[$];
    bit g_lsu[$];
    int quiet, hits;

    initial begin
        rst = 1; ifu_req = 0; lsu_req = 0; lsu_we = 0;
        ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_silent = 0; stray_rv = 0; stray_wv = 0;
        drain(2);
        @(negedge clk);
        check("lit_reset_ce", mem_ce, 1'b0);
        step(); rst = 0;
        @(negedge clk);
        check("lit_ce_after_reset", mem_ce, 1'b1);

        // IFU read
        step(); ifu_req = 1; ifu_addr = 64'h8000_0000;
        @(negedge clk);
        check("lit_ifu_gnt", ifu_gnt, 1'b1);
        check("lit_ifu_raddr", mem_raddr, 64'h8000_0000);
        step(); ifu_req = 0;
        step();
        @(negedge clk);
        check("lit_ifu_rvalid", ifu_rvalid, 1'b1);
        check("lit_ifu_rdata", ifu_rdata, 64'hDEAD_BEEF_0000_0013);
        step();

        // LSU write
        step(); lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_0100;
        lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'h0F;
        @(negedge clk);
        check("lit_lsu_wen", mem_wen, 1'b1);
        check("lit_lsu_we", mem_we, 8'h0F);
        step(); lsu_req = 0; lsu_we = 0;
        step();
        @(negedge clk);
        check("lit_lsu_wdone", lsu_rvalid, 1'b1);
        check("lit_lsu_wrdata", lsu_rdata, 64'd0);
        step();

        // LSU read
        step(); lsu_req = 1; lsu_addr = 64'h8000_0200;
        step(); lsu_req = 0;
        step();
        @(negedge clk);
        check("lit_lsu_rdata", lsu_rdata, 64'h7FFF_FDFF_8000_0200);
        step();

        // Contention from reset
        step(); rst = 1; ifu_req = 1; lsu_req = 1; lsu_we = 0;
        ifu_addr = 64'h8000_0040; lsu_addr = 64'h8000_0300;
        step(); rst = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ifu_gnt || lsu_gnt) begin g_cyc.push_back(i); g_lsu.push_back(lsu_gnt); end
            step();
        end
        ifu_req = 0; lsu_req = 0;
        drain(4);
        check("lit_cont_count", 64'(g_cyc.size()), 64'd5);
        if (g_cyc.size() >= 4) begin
            check("lit_cont_first", 64'(g_cyc[0]), 64'd0);
            check("lit_cont_o0", 64'(g_lsu[0]), 64'd1);
            check("lit_cont_o1", 64'(g_lsu[1]), 64'd0);
            check("lit_cont_o2", 64'(g_lsu[2]), 64'd1);
            check("lit_cont_o3", 64'(g_lsu[3]), 64'd0);
            check("lit_cont_gap1", 64'(g_cyc[1] - g_cyc[0]), 64'd3);
            check("lit_cont_gap3", 64'(g_cyc[3] - g_cyc[2]), 64'd3);
        end

        // Timeout on an LSU read, IFU waiting behind it
        mem_silent = 1;
        step(); lsu_req = 1; lsu_addr = 64'h8000_0400;
        @(negedge clk);
        check("lit_to_gnt", lsu_gnt, 1'b1);
        step(); lsu_req = 0; mem_silent = 0; ifu_req = 1; ifu_addr = 64'h8000_0000;
        quiet = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (lsu_rvalid) quiet++;
            step();
        end
        check("lit_to_quiet", 64'(quiet), 64'd0);
        @(negedge clk);
        check("lit_to_rvalid", lsu_rvalid, 1'b1);
        check("lit_to_err", lsu_err, 1'b1);
        check("lit_to_rdata", lsu_rdata, 64'd0);
        step();
        @(negedge clk);
        check("lit_to_next_gnt", ifu_gnt, 1'b1);
        step(); ifu_req = 0;
        drain(3);

        // Reset mid-transaction, then a tie
        step(); ifu_req = 1; ifu_addr = 64'h8000_0000;
        @(negedge clk);
        check("lit_rm_gnt", ifu_gnt, 1'b1);
        step(); rst = 1; ifu_req = 0;
        @(negedge clk);
        check("lit_rm_outs", {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_ren, mem_wen}, 64'd0);
        step(); rst = 0; ifu_req = 1; lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_0500;
        @(negedge clk);
        check("lit_rm_no_rvalid", ifu_rvalid, 1'b0);
        check("lit_rm_lsu_first", lsu_gnt, 1'b1);
        step(); ifu_req = 0; lsu_req = 0;
        drain(4);

        // Stray read valid while idle
        step(); stray_rv = 1;
        step(); stray_rv = 0;
        @(negedge clk);
        check("lit_stray_none", {ifu_rvalid, lsu_rvalid}, 64'd0);
        step(); ifu_req = 1; ifu_addr = 64'h8000_0008;
        step(); ifu_req = 0;
        drain(3);

        // Write-done during an IFU wait must not complete it
        mem_silent = 1;
        step(); ifu_req = 1; ifu_addr = 64'h8000_0010;
        step(); ifu_req = 0; mem_silent = 0; stray_wv = 1;
        step(); stray_wv = 0;
        hits = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (ifu_rvalid && ifu_err) hits++;
            step();
        end
        check("lit_wrongvalid_timeout", 64'(hits), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
